// File: rtl/riscv_irq_ctrl.sv
// Fixed-priority, non-nesting interrupt controller between level-sensitive peripherals and the core trap port.
// Latency: pend->req 1 cycle, mret->ack 1 cycle; the request is held while the core stalls, and new pends wait until IDLE.
module riscv_irq_ctrl #(
  parameter int IRQ_NUM    = 16,
  parameter int CAUSE_BASE = 16,
  localparam int IDX_W     = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic [IRQ_NUM-1:0] mie_i,
  input  logic               stall_i,
  input  logic               irq_ret_i,
  output logic               irq_req_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ack_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IRQ_NUM-1:0] pend;
  logic [IDX_W-1:0]   sel;

  assign pend = irq_i & mie_i;

  // Scan from the top so the lowest set bit is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pend[i]) sel = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          idx_d   = sel;
          state_d = REQ;
        end
      end
      REQ:  if (!stall_i) state_d = SERV;
      SERV: if (irq_ret_i) state_d = ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on the registered state and index.
  always_comb begin
    irq_req_o   = (state_q == REQ);
    busy_o      = (state_q != IDLE);
    irq_cause_o = '0;
    irq_ack_o   = '0;
    if (state_q != IDLE) irq_cause_o = {1'b1, 31'(CAUSE_BASE) + 31'(idx_q)};
    for (int i = 0; i < IRQ_NUM; i++) begin
      irq_ack_o[i] = (state_q == ACK) && (idx_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl: reset, single source, priority, stall hold, spurious mret, masking, reset mid-service.
module tb_riscv_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_i;
  logic [15:0] mie_i;
  logic        stall_i;
  logic        irq_ret_i;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ack_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  riscv_irq_ctrl #(.IRQ_NUM(16), .CAUSE_BASE(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_i       (irq_i),
    .mie_i       (mie_i),
    .stall_i     (stall_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_cause_o (irq_cause_o),
    .irq_ack_o   (irq_ack_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Output snapshot packed as {req, cause, ack, busy}.
  function automatic logic [49:0] obs();
    return {irq_req_o, irq_cause_o, irq_ack_o, busy_o};
  endfunction

  function automatic logic [49:0] pk(input logic r, input logic [31:0] c, input logic [15:0] a, input logic b);
    return {r, c, a, b};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [49:0] e;
    rst_i = 1'b0; irq_i = 16'hFFFF; mie_i = 16'hFFFF; stall_i = 1'b0; irq_ret_i = 1'b0;
    e = pk(1'b0, 32'h0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs(), e); end
    end
    mie_i = 16'h0000;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL reset_masked got=%h exp=%h", obs(), e); end
    end
    irq_i = 16'h0000;
    step();
  endtask

  task automatic test_single();
    logic [49:0] e;
    mie_i = 16'hFFFF; irq_i = 16'h0008;
    step();
    e = pk(1'b1, 32'h8000_0013, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL single_req got=%h exp=%h", obs(), e); end
    step();
    e = pk(1'b0, 32'h8000_0013, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL single_serv got=%h exp=%h", obs(), e); end
    irq_ret_i = 1'b1;
    step();
    irq_ret_i = 1'b0; irq_i = 16'h0000;
    e = pk(1'b0, 32'h8000_0013, 16'h0008, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL single_ack got=%h exp=%h", obs(), e); end
    step();
    e = pk(1'b0, 32'h0, 16'h0, 1'b0);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL single_idle got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_priority();
    logic [49:0] e;
    irq_i = 16'h0024;
    step();
    e = pk(1'b1, 32'h8000_0012, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL prio_first_req got=%h exp=%h", obs(), e); end
    step();
    irq_ret_i = 1'b1;
    step();
    irq_ret_i = 1'b0; irq_i = 16'h0020;
    e = pk(1'b0, 32'h8000_0012, 16'h0004, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL prio_first_ack got=%h exp=%h", obs(), e); end
    step();
    e = pk(1'b0, 32'h0, 16'h0, 1'b0);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL prio_gap_idle got=%h exp=%h", obs(), e); end
    step();
    e = pk(1'b1, 32'h8000_0015, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL prio_second_req got=%h exp=%h", obs(), e); end
    step();
    irq_ret_i = 1'b1;
    step();
    irq_ret_i = 1'b0; irq_i = 16'h0000;
    e = pk(1'b0, 32'h8000_0015, 16'h0020, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL prio_second_ack got=%h exp=%h", obs(), e); end
    step();
  endtask

  task automatic test_stall_hold();
    logic [49:0] e;
    stall_i = 1'b1; irq_i = 16'h0001;
    step();
    e = pk(1'b1, 32'h8000_0010, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, obs(), e); end
      if (i == 1) begin mie_i = 16'h0000; irq_i = 16'h0000; end
      if (i == 2) mie_i = 16'h0002;
      if (i < 3) step();
    end
    stall_i = 1'b0;
    step();
    mie_i = 16'hFFFF; irq_i = 16'h0001;
    e = pk(1'b0, 32'h8000_0010, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL stall_release got=%h exp=%h", obs(), e); end
    irq_ret_i = 1'b1;
    step();
    irq_ret_i = 1'b0; irq_i = 16'h0000;
    e = pk(1'b0, 32'h8000_0010, 16'h0001, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL stall_ack got=%h exp=%h", obs(), e); end
    step();
  endtask

  task automatic test_spurious_ret();
    logic [49:0] e;
    irq_ret_i = 1'b1;
    step();
    e = pk(1'b0, 32'h0, 16'h0, 1'b0);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL ret_in_idle got=%h exp=%h", obs(), e); end
    stall_i = 1'b1; irq_i = 16'h0002;
    step();
    step();
    e = pk(1'b1, 32'h8000_0011, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL ret_in_req got=%h exp=%h", obs(), e); end
    irq_ret_i = 1'b0; stall_i = 1'b0;
    step();
    irq_ret_i = 1'b1;
    step();
    irq_ret_i = 1'b0; irq_i = 16'h0000;
    e = pk(1'b0, 32'h8000_0011, 16'h0002, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL ret_round_ack got=%h exp=%h", obs(), e); end
    step();
  endtask

  task automatic test_masked();
    logic [49:0] e;
    mie_i = 16'hFFEF; irq_i = 16'h0010;
    step();
    step();
    e = pk(1'b0, 32'h0, 16'h0, 1'b0);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL masked_idle got=%h exp=%h", obs(), e); end
    mie_i = 16'hFFFF;
    step();
    e = pk(1'b1, 32'h8000_0014, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL unmask_req got=%h exp=%h", obs(), e); end
    step();
    irq_ret_i = 1'b1;
    step();
    irq_ret_i = 1'b0; irq_i = 16'h0000;
    step();
  endtask

  task automatic test_reset_mid_service();
    logic [49:0] e;
    irq_i = 16'h0002;
    step();
    step();
    e = pk(1'b0, 32'h8000_0011, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL midrst_serv got=%h exp=%h", obs(), e); end
    rst_i = 1'b0;
    #1;
    e = pk(1'b0, 32'h0, 16'h0, 1'b0);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL midrst_immediate got=%h exp=%h", obs(), e); end
    irq_ret_i = 1'b1;
    step();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL midrst_no_ack got=%h exp=%h", obs(), e); end
    irq_ret_i = 1'b0;
    rst_i = 1'b1;
    step();
    e = pk(1'b1, 32'h8000_0011, 16'h0, 1'b1);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL midrst_rereq got=%h exp=%h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_stall_hold();
    test_spurious_ret();
    test_masked();
    test_reset_mid_service();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
